sipo: RTL
=========

Name: sipo

Overview:
- Serial-in parallel-out receiver; the far end of the start/data/stop serial line that the team's PISO transmitter drives.
- Samples one bit per sr_clk_i edge, with no oversampling; the link shares the BSC-derived clock.
- Frame: line idles 1, start bit 0, DATA_W data bits MSB first, stop bit 1.
- Delivers each received word on a valid/ack holding register to the microprocessor side, and flags framing errors and overruns.

Parameters:
- DATA_W, 8, number of data bits per frame (MSB first on the line).

Ports:
- sr_clk_i  input  1  bit clock (BSC-modified clock); all state updates on posedge.
- rst_i  input  1  asynchronous active-high reset.
- data_i  input  1  serial line; idles 1.
- ack_i  input  1  consumer acknowledges data_o; sampled only while valid_o=1.
- data_o  output  DATA_W  last good word received.
- valid_o  output  1  data_o holds an unacknowledged word.
- busy_o  output  1  frame reception in progress (state != IDLE).
- frame_err_o  output  1  one-cycle pulse: stop bit sampled 0.
- overrun_o  output  1  sticky: a word was overwritten before ack.

Behaviour:
- Reset (async, any time including mid-frame):
  - state=IDLE, bit counter=0, shift register=0.
  - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
  - A partial frame is discarded.
- States: IDLE, DATA, STOP, BREAK (2-bit encoding).
- IDLE: data_i=0 sampled -> DATA, counter=0; else stay.
- DATA:
  - Each edge: shreg <= {shreg[DATA_W-2:0], data_i}; counter++.
  - When counter == DATA_W-1 (last data bit being sampled) -> STOP.
- STOP, data_i=1: data_o <= completed shreg; valid_o <= 1; -> IDLE.
- STOP, data_i=0: frame_err_o pulses 1 for one cycle; shreg discarded; data_o/valid_o unchanged; -> BREAK.
- BREAK: wait for data_i=1 -> IDLE. A line held low never creates spurious frames.
- Timing, with the start bit sampled at edge 0:
  - Data bits are sampled at edges 1..DATA_W; stop bit at edge DATA_W+1.
  - valid_o is high after edge DATA_W+1 (10 edges for DATA_W=8).
- Back-to-back frames: a start bit on the edge immediately after the stop edge is accepted. This covers the transmitter's minimum 1-cycle idle gap.
- busy_o = (state != IDLE); it is high through BREAK.
- ack_i:
  - valid_o=1 and ack_i=1 at an edge: valid_o <= 0 and overrun_o <= 0, unless a word completes on the same edge.
  - ack_i with valid_o=0 is ignored.
- Word completes while valid_o=1 and ack_i=0: data_o overwritten with the new word, valid_o stays 1, overrun_o <= 1.
- Word completes while valid_o=1 and ack_i=1: new word loaded, valid_o stays 1, overrun_o unchanged.
- No parity; counter width = $clog2(DATA_W).

Optional Feature:
- Macro SIPO_SYNC_EN.
- Defined:
  - data_i passes through a 2-flop synchronizer, reset to 1, before the FSM.
  - All sampling points, and valid_o rise, shift 2 cycles later (12 edges after start for DATA_W=8).
  - Used when the line comes from another board or clock domain.
- Undefined: data_i feeds the FSM directly; timing as in Behaviour.

Decomposition:
- Shared package (serial_pkg): FSM state typedef (IDLE/DATA/STOP/BREAK), START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1, default DATA_W.
- The transmitter shares serial_pkg.
- One natural sub-module, sipo_sync: the 2-flop synchronizer, instantiated only under SIPO_SYNC_EN.
- FSM, shift register and holding register stay in sipo.

Test Plan:
- Reset, drive frame 0,0,0,1,0,1,1,0,0,1 (0x2C) -> valid_o=1, data_o=8'h2C after 10 edges; frame_err_o=0; busy_o high edges 1..10. Then ack_i=1 one cycle -> valid_o=0.
- Frame 0x D2 with stop bit 0 -> frame_err_o pulses once, data_o/valid_o unchanged. Line held 0 for 5 more cycles -> stays BREAK, no new frame. Line 1 then frame 0x2A -> data_o=8'h2A.
- Frames 0x2C then 0x2A back-to-back with one idle cycle, no ack -> data_o=8'h2A, valid_o=1, overrun_o=1. ack_i -> valid_o=0, overrun_o=0.
- ack_i asserted on the same edge the second word completes -> data_o=new word, valid_o=1, overrun_o=0.
- rst_i pulsed after 4 data bits of 0xFF -> all outputs at reset values. Next clean frame 0x5A received correctly.
- SIPO_SYNC_EN defined, frame 0x2C -> data_o=8'h2C with valid_o rising 2 cycles later than in the non-sync build.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial-link definitions for the PISO transmitter and SIPO receiver.
package serial_pkg;
  typedef enum logic [1:0] {IDLE, DATA, STOP, BREAK} state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_W_DEF = 8;
endpackage

// File: rtl/sipo_if.sv
// SIPO receiver bus: serial line in, word/flag outputs to the microprocessor side.
interface sipo_if #(parameter int DATA_W = 8);
  logic              data_i;
  logic              ack_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              busy_o;
  logic              frame_err_o;
  logic              overrun_o;

  modport master (output data_i, ack_i,
                  input  data_o, valid_o, busy_o, frame_err_o, overrun_o);
  modport slave  (input  data_i, ack_i,
                  output data_o, valid_o, busy_o, frame_err_o, overrun_o);
endinterface

// File: rtl/sipo_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle level so no false start bit appears.
import serial_pkg::*;

module sipo_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], d_i};

  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= {2{IDLE_LEVEL}};
    else     sync_q <= sync_d;

  assign q_o = sync_q[1];
endmodule

// File: rtl/sipo.sv
// Serial-in parallel-out receiver: start/DATA_W bits MSB first/stop, valid/ack holding register.
// Define SIPO_SYNC_EN to insert a 2-flop synchronizer on data_i (adds 2 cycles of latency).
import serial_pkg::*;

module sipo #(
  parameter int DATA_W = DATA_W_DEF
) (
  input logic  sr_clk_i,
  input logic  rst_i,
  sipo_if.slave bus
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic rx;
`ifdef SIPO_SYNC_EN
  sipo_sync u_sync (.clk(sr_clk_i), .rst(rst_i), .d_i(bus.data_i), .q_o(rx));
`else
  assign rx = bus.data_i;
`endif

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (valid_q && bus.ack_i) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      IDLE:
        if (rx == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      DATA: begin
        shreg_d = {shreg_q[DATA_W-2:0], rx};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W-1)) state_d = STOP;
      end
      STOP: begin
        if (rx == STOP_BIT) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
          // A completion keeps the overrun flag as-is when acked, sets it when not.
          if (valid_q) ovr_d = bus.ack_i ? ovr_q : 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          shreg_d = '0;
          state_d = BREAK;
        end
      end
      BREAK:
        if (rx == IDLE_LEVEL) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sr_clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.frame_err_o = ferr_q;
  assign bus.overrun_o   = ovr_q;
endmodule
